// File: rtl/fib_seq_engine_if.sv
// Bus bundle for fib_seq_engine: run control, result read port and status.
// Handshake: start is a level sampled only while the engine is idle; the edge that sees it
// accepted latches n_terms, and done later pulses for exactly one cycle. Reads have one-cycle latency.
interface fib_seq_engine_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic             start;
  logic [AW:0]      n_terms;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             busy;
  logic             done;
  logic [AW:0]      count;
  logic             ovf;
  logic [1:0]       state_dbg;

  modport master (
    output start, n_terms, rd_addr,
    input  rd_data, busy, done, count, ovf, state_dbg
  );

  modport slave (
    input  start, n_terms, rd_addr,
    output rd_data, busy, done, count, ovf, state_dbg
  );
endinterface

// File: rtl/fib_seq_engine.sv
// Fibonacci sequence engine: writes up to DEPTH terms into a register file readable at any time.
// Define FIB_OVF_STOP_EN to end a run at the first term that does not fit in WIDTH bits.
module fib_seq_engine #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic reset,
  fib_seq_engine_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] N_MAX = (AW+1)'(DEPTH);

`ifdef FIB_OVF_STOP_EN
  localparam bit STOP_ON_OVF = 1'b1;
`else
  localparam bit STOP_ON_OVF = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [AW:0]      n_q, count_q, count_inc, n_clamped;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH:0]   sum;
  logic             a_ovf_q, b_ovf_q;
  logic             ovf_q, done_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;
  logic             load, wr_en, stop_ovf;

  assign n_clamped = (bus.n_terms > N_MAX) ? N_MAX : bus.n_terms;
  assign count_inc = count_q + (AW+1)'(1);
  assign sum       = {1'b0, a_q} + {1'b0, b_q};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    wr_en    = 1'b0;
    stop_ovf = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = (n_clamped == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (a_ovf_q && STOP_ON_OVF) begin
          stop_ovf = 1'b1;
          state_d  = DONE;
        end else begin
          wr_en = 1'b1;
          if (count_inc == n_q) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // a_ovf_q marks that the term held in a_q is a wrapped value, not the true Fibonacci number.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n_q     <= '0;
      count_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      a_ovf_q <= 1'b0;
      b_ovf_q <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= (state_q == DONE);
      if (load) begin
        n_q     <= n_clamped;
        count_q <= '0;
        ovf_q   <= 1'b0;
        a_q     <= '0;
        b_q     <= WIDTH'(1);
        a_ovf_q <= 1'b0;
        b_ovf_q <= 1'b0;
      end else if (stop_ovf) begin
        ovf_q <= 1'b1;
      end else if (wr_en) begin
        a_q     <= b_q;
        b_q     <= sum[WIDTH-1:0];
        a_ovf_q <= b_ovf_q;
        b_ovf_q <= sum[WIDTH] | a_ovf_q | b_ovf_q;
        count_q <= count_inc;
        if (a_ovf_q) ovf_q <= 1'b1;
      end
    end
  end

  // Read samples the pre-write contents, so a same-cycle read of the written address returns old data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem_q[bus.rd_addr];
      if (wr_en) mem_q[count_q[AW-1:0]] <= a_q;
    end
  end

  assign bus.rd_data   = rd_data_q;
  assign bus.busy      = (state_q == RUN);
  assign bus.done      = done_q;
  assign bus.count     = count_q;
  assign bus.ovf       = ovf_q;
  assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_fib_seq_engine.sv
// Bench for fib_seq_engine: a 16-bit and an 8-bit instance driven in lockstep, checked against
// a true-precision Fibonacci model with a read-back scoreboard.
module tb_fib_seq_engine;
  localparam int DEPTH = 16;

`ifdef FIB_OVF_STOP_EN
  localparam bit STOP_EN = 1'b1;
`else
  localparam bit STOP_EN = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       start;
  logic [4:0] n_terms;
  logic [3:0] rd_addr;

  int checks = 0;
  int passes = 0;

  int m16 [DEPTH];
  int m8  [DEPTH];
  logic [31:0] exp16_q [$];
  logic [31:0] exp8_q  [$];

  fib_seq_engine_if #(.WIDTH(16), .DEPTH(DEPTH)) if16 ();
  fib_seq_engine_if #(.WIDTH(8),  .DEPTH(DEPTH)) if8 ();

  assign if16.start   = start;
  assign if16.n_terms = n_terms;
  assign if16.rd_addr = rd_addr;
  assign if8.start    = start;
  assign if8.n_terms  = n_terms;
  assign if8.rd_addr  = rd_addr;

  fib_seq_engine #(.WIDTH(16), .DEPTH(DEPTH)) u_dut16 (.clk(clk), .reset(reset), .bus(if16));
  fib_seq_engine #(.WIDTH(8),  .DEPTH(DEPTH)) u_dut8  (.clk(clk), .reset(reset), .bus(if8));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Reference: true-precision Fibonacci, reduced to w bits when stored.
  task automatic model(input int nt, input int w, output int cnt, output int ov, output int busy_c);
    longint lim, f0, f1, t;
    int n;
    lim    = longint'(1) << w;
    n      = (nt > DEPTH) ? DEPTH : nt;
    cnt    = 0;
    ov     = 0;
    busy_c = n;
    f0     = 0;
    f1     = 1;
    for (int k = 0; k < n; k++) begin
      if (f0 >= lim) begin
        ov = 1;
        if (STOP_EN) begin
          busy_c = k + 1;
          break;
        end
      end
      if (w == 16) m16[k] = int'(f0 % lim);
      else         m8[k]  = int'(f0 % lim);
      cnt = k + 1;
      t  = f0 + f1;
      f0 = f1;
      f1 = t;
    end
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = 4'(a);
      exp16_q.push_back(32'(m16[a]));
      exp8_q.push_back(32'(m8[a]));
      @(posedge clk); #1;
      chk($sformatf("rd16[%0d]", a), 32'(if16.rd_data), exp16_q.pop_front());
      chk($sformatf("rd8[%0d]", a),  32'(if8.rd_data),  exp8_q.pop_front());
    end
  endtask

  // driver: one run, observed for a fixed window, then full read-back
  task automatic run(input int nt, input bit repulse);
    int c16, o16, b16, c8, o8, b8;
    int old16, old8;
    int bz16, bz8, dn16, dn8, di16, di8;
    bz16 = 0; bz8 = 0; dn16 = 0; dn8 = 0; di16 = -1; di8 = -1;
    old16 = m16[2];
    old8  = m8[2];
    model(nt, 16, c16, o16, b16);
    model(nt, 8,  c8,  o8,  b8);
    rd_addr = 4'd2;
    start   = 1'b1;
    n_terms = 5'(nt);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 22; i++) begin
      if (i == 3) begin
        chk("rd16_during_write", 32'(if16.rd_data), 32'(old16));
        chk("rd8_during_write",  32'(if8.rd_data),  32'(old8));
      end
      if (repulse && i == 3) begin
        start   = 1'b1;
        n_terms = 5'd3;
      end else begin
        start = 1'b0;
      end
      if (if16.busy) bz16++;
      if (if8.busy)  bz8++;
      if (if16.done) begin dn16++; if (di16 < 0) di16 = i; end
      if (if8.done)  begin dn8++;  if (di8 < 0)  di8 = i;  end
      @(posedge clk); #1;
    end
    chk($sformatf("n%0d count16", nt), 32'(if16.count), 32'(c16));
    chk($sformatf("n%0d count8", nt),  32'(if8.count),  32'(c8));
    chk($sformatf("n%0d ovf16", nt),   32'(if16.ovf),   32'(o16));
    chk($sformatf("n%0d ovf8", nt),    32'(if8.ovf),    32'(o8));
    chk($sformatf("n%0d busy16", nt),  32'(bz16), 32'(b16));
    chk($sformatf("n%0d busy8", nt),   32'(bz8),  32'(b8));
    chk($sformatf("n%0d done16_n", nt), 32'(dn16), 32'd1);
    chk($sformatf("n%0d done8_n", nt),  32'(dn8),  32'd1);
    chk($sformatf("n%0d done16_at", nt), 32'(di16), 32'(b16 + 1));
    chk($sformatf("n%0d done8_at", nt),  32'(di8),  32'(b8 + 1));
    chk($sformatf("n%0d state16", nt), 32'(if16.state_dbg), 32'd0);
    read_all();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " busy16"},  32'(if16.busy),      32'd0);
    chk({tag, " done16"},  32'(if16.done),      32'd0);
    chk({tag, " count16"}, 32'(if16.count),     32'd0);
    chk({tag, " ovf16"},   32'(if16.ovf),       32'd0);
    chk({tag, " rd16"},    32'(if16.rd_data),   32'd0);
    chk({tag, " state16"}, 32'(if16.state_dbg), 32'd0);
    chk({tag, " busy8"},   32'(if8.busy),       32'd0);
    chk({tag, " count8"},  32'(if8.count),      32'd0);
    chk({tag, " rd8"},     32'(if8.rd_data),    32'd0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      m16[i] = 0;
      m8[i]  = 0;
    end
    reset   = 1'b0;
    start   = 1'b0;
    n_terms = '0;
    rd_addr = '0;
    #12;
    chk_reset_outputs("por");
    reset = 1'b1;

    // first start lands on the first edge after reset release
    run(10, 1'b0);
    run(16, 1'b0);
    // second start mid-run must be ignored; upper addresses keep the 16-term values
    run(10, 1'b1);
    run(0, 1'b0);
    run(20, 1'b0);

    // reset in the middle of a run
    start   = 1'b1;
    n_terms = 5'd10;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("pre_reset count16", 32'(if16.count), 32'd4);
    reset = 1'b0;
    #1;
    chk_reset_outputs("midrun");
    for (int i = 0; i < DEPTH; i++) begin
      m16[i] = 0;
      m8[i]  = 0;
    end
    @(posedge clk); #1;
    reset = 1'b1;
    read_all();
    chk("post_reset done16", 32'(if16.done), 32'd0);

    // short reset pulse, then start on the very next edge
    reset = 1'b0;
    #4;
    reset = 1'b1;
    run(7, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
